nonce_serializer: RTL and testbench

NONCE_SERIALIZER -- requirements
Module: nonce_serializer

---
 rtl/nonce_serializer_if.sv | 20 ++
 rtl/nonce_serializer.sv | 54 +++++
 tb/tb_nonce_serializer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/nonce_serializer_if.sv
// nonce_serializer_if: nonce request and byte-stream handshake bundle
interface nonce_serializer_if #(
  parameter int NONCE_WIDTH = 256
);
  logic                   start_i;
  logic [NONCE_WIDTH-1:0] nonce_i;
  logic                   busy_o;
  logic                   done_o;
  logic                   tx_valid_o;
  logic [7:0]             tx_data_o;
  logic                   tx_ready_i;
  modport master (
    output start_i, nonce_i, tx_ready_i,
    input  busy_o, done_o, tx_valid_o, tx_data_o
  );
  modport slave (
    input  start_i, nonce_i, tx_ready_i,
    output busy_o, done_o, tx_valid_o, tx_data_o
  );
endinterface

// File: rtl/nonce_serializer.sv
// nonce_serializer: streams a nonce out LSB byte first over a valid/ready byte port
module nonce_serializer #(
  parameter  int NONCE_WIDTH = 256,
  localparam int NUM_BYTES   = NONCE_WIDTH / 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  nonce_serializer_if.slave bus
);
  localparam int CW = $clog2(NUM_BYTES) + 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t                 state_q, state_d;
  logic [NONCE_WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   xfer, last;
  assign xfer           = (state_q == SEND) && bus.tx_ready_i;
  assign last           = cnt_q == CW'(NUM_BYTES - 1);
  assign bus.busy_o     = state_q == SEND;
  assign bus.tx_valid_o = state_q == SEND;
  assign bus.tx_data_o  = (state_q == SEND) ? sr_q[7:0] : 8'h00;
  assign bus.done_o     = done_q;
  // State, shift register, byte counter and done pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  // Load on accepted start, shift one byte per transfer, finish after the last byte
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == IDLE && bus.start_i) begin
      state_d = SEND;
      sr_d    = bus.nonce_i;
      cnt_d   = '0;
    end else if (xfer) begin
      sr_d    = sr_q >> 8;
      cnt_d   = cnt_q + 1'b1;
      state_d = last ? IDLE : SEND;
      done_d  = last;
    end
  end
endmodule

// File: tb/tb_nonce_serializer.sv
// tb_nonce_serializer: directed and random-stall checks of the nonce byte serializer
module tb_nonce_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int nxf = 0;
  int ndone = 0;
  logic [255:0] rx = '0;
  logic [255:0] n0, n1, nr;
  nonce_serializer_if #(.NONCE_WIDTH(256)) bus ();
  nonce_serializer #(.NONCE_WIDTH(256)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Called at a negedge with inputs already set: logs the transfer of the coming posedge, then advances
  task automatic step();
    if (bus.tx_valid_o && bus.tx_ready_i) begin
      rx = {bus.tx_data_o, rx[255:8]};
      nxf++;
    end
    if (bus.done_o) ndone++;
    @(negedge clk);
  endtask
  task automatic start(input logic [255:0] n);
    bus.start_i = 1'b1;
    bus.nonce_i = n;
    rx = '0;
    nxf = 0;
    ndone = 0;
    step();
    bus.start_i = 1'b0;
  endtask
  task automatic run_to_done(input bit rnd);
    int n = 0;
    while (!bus.done_o && n < 2000) begin
      if (rnd) bus.tx_ready_i = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    bus.tx_ready_i = 1'b1;
    chk("done_reached", {255'd0, bus.done_o}, 256'd1);
  endtask
  initial begin
    bus.start_i = 1'b0;
    bus.nonce_i = '0;
    bus.tx_ready_i = 1'b1;
    for (int i = 0; i < 32; i++) n0[i*8 +: 8] = 8'(i);
    n1 = 256'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_C0FF_EE00_1122_3344_5566_7788;
    #1;
    chk("rst_busy", {255'd0, bus.busy_o}, 256'd0);
    chk("rst_done", {255'd0, bus.done_o}, 256'd0);
    chk("rst_valid", {255'd0, bus.tx_valid_o}, 256'd0);
    chk("rst_data", {248'd0, bus.tx_data_o}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_valid", {255'd0, bus.tx_valid_o}, 256'd0);
    // in-order stream with ready held high
    start(n0);
    for (int i = 0; i < 32; i++) begin
      chk("seq_valid", {255'd0, bus.tx_valid_o}, 256'd1);
      chk("seq_data", {248'd0, bus.tx_data_o}, 256'(i));
      step();
    end
    chk("seq_done", {255'd0, bus.done_o}, 256'd1);
    chk("seq_busy", {255'd0, bus.busy_o}, 256'd0);
    chk("seq_idle_valid", {255'd0, bus.tx_valid_o}, 256'd0);
    chk("seq_rx", rx, n0);
    // start accepted in the done cycle
    start({32{8'hA5}});
    chk("b2b_valid", {255'd0, bus.tx_valid_o}, 256'd1);
    chk("b2b_data", {248'd0, bus.tx_data_o}, 256'hA5);
    run_to_done(1'b0);
    chk("b2b_nxf", 256'(nxf), 256'd32);
    chk("b2b_rx", rx, {32{8'hA5}});
    step();
    chk("done_one_cycle", {255'd0, bus.done_o}, 256'd0);
    // five-cycle stall on byte 3
    start(n0);
    repeat (3) step();
    bus.tx_ready_i = 1'b0;
    repeat (5) begin
      chk("stall_valid", {255'd0, bus.tx_valid_o}, 256'd1);
      chk("stall_data", {248'd0, bus.tx_data_o}, 256'h03);
      step();
    end
    bus.tx_ready_i = 1'b1;
    run_to_done(1'b0);
    chk("stall_nxf", 256'(nxf), 256'd32);
    chk("stall_rx", rx, n0);
    step();
    // second start during SEND is ignored
    start(n0);
    repeat (10) step();
    chk("ign_data", {248'd0, bus.tx_data_o}, 256'h0A);
    bus.start_i = 1'b1;
    bus.nonce_i = n1;
    step();
    bus.start_i = 1'b0;
    run_to_done(1'b0);
    chk("ign_nxf", 256'(nxf), 256'd32);
    chk("ign_rx", rx, n0);
    step();
    // asynchronous reset mid-stream at byte 7
    start(n0);
    repeat (7) step();
    chk("pre_rst_data", {248'd0, bus.tx_data_o}, 256'h07);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {255'd0, bus.busy_o}, 256'd0);
    chk("arst_valid", {255'd0, bus.tx_valid_o}, 256'd0);
    chk("arst_data", {248'd0, bus.tx_data_o}, 256'd0);
    chk("arst_done", {255'd0, bus.done_o}, 256'd0);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.nonce_i = n1;
    step();
    step();
    chk("rst_no_start", {255'd0, bus.tx_valid_o}, 256'd0);
    bus.start_i = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_idle", {255'd0, bus.tx_valid_o}, 256'd0);
    chk("post_rst_nodone", 256'(ndone), 256'd0);
    start(n1);
    chk("restart_data", {248'd0, bus.tx_data_o}, 256'h88);
    run_to_done(1'b0);
    chk("restart_rx", rx, n1);
    step();
    // random nonces with random ready stalls, reassembled at the MSB end
    for (int it = 0; it < 100; it++) begin
      for (int w = 0; w < 8; w++) nr[w*32 +: 32] = $urandom;
      start(nr);
      run_to_done(1'b1);
      chk("loop_rx", rx, nr);
      chk("loop_nxf", 256'(nxf), 256'd32);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
